// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl -- stall, flush and forwarding control for a 5-stage pipe.
//
// Ports
//   clk, reset      rising-edge clock, async active-low reset
//   id_op/rs/rt     instruction in ID (opcode, source fields)
//   ex_op/rd/rs/rt  instruction in EX
//   mem_op/rd       instruction in MEM
//   wb_op/rd        instruction in WB
//   br_taken        control-flow instruction in EX resolved taken
//   pc_write        PC load enable
//   ifid_write      IF/ID load enable
//   ifid_flush      squash IF/ID to NOP
//   idex_flush      insert bubble into ID/EX
//   fwd_a, fwd_b    EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt       saturating count of cycles with pc_write=0
//   flush_cnt       saturating count of cycles with ifid_flush=1
//   state           00 RUN, 01 STALL, 10 FLUSH
//
// Control outputs respond in the same cycle as the hazard, so they are
// decoded from the registered state plus the live stage opcodes.

// One forwarding-select lane: picks EX/MEM over MEM/WB for a single operand.
module pipeline_hazard_fwd_sel (
  input  logic       rd_en,    // EX instruction reads this operand
  input  logic       mem_fwd,  // MEM holds a forwardable (non-load) writer
  input  logic [5:0] mem_rd,
  input  logic       wb_fwd,   // WB holds a writer
  input  logic [5:0] wb_rd,
  input  logic [5:0] src,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (rd_en && mem_fwd && mem_rd == src)     sel = 2'b10;
    else if (rd_en && wb_fwd && wb_rd == src)  sel = 2'b01;
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int LU_STALLS  = 1,
  parameter int BR_PENALTY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  id_op,
  input  logic [5:0]  id_rs,
  input  logic [5:0]  id_rt,
  input  logic [3:0]  ex_op,
  input  logic [5:0]  ex_rd,
  input  logic [5:0]  ex_rs,
  input  logic [5:0]  ex_rt,
  input  logic [3:0]  mem_op,
  input  logic [5:0]  mem_rd,
  input  logic [3:0]  wb_op,
  input  logic [5:0]  wb_rd,
  input  logic        br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [1:0]  state
);
  localparam int          NUM_OPS = 2;  // rs lane 0, rt lane 1
  localparam logic [3:0]  OP_LD   = 4'hE;
  localparam logic [1:0]  LU_INIT = 2'(LU_STALLS - 1);
  localparam logic [1:0]  BR_INIT = 2'(BR_PENALTY - 1);

  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

  function automatic logic is_wr(input logic [3:0] op);
    return op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE, 4'hF};
  endfunction
  function automatic logic rd_rs(input logic [3:0] op);
    return op inside {4'h3, [4'h4:4'h7], [4'h8:4'hB], 4'hE};
  endfunction
  function automatic logic rd_rt(input logic [3:0] op);
    return op inside {4'h3, 4'h4, 4'h7};
  endfunction

  // forwarding lanes
  logic [NUM_OPS-1:0]      fw_en;
  logic [NUM_OPS-1:0][5:0] fw_src;
  logic [NUM_OPS-1:0][1:0] fw_sel;
  logic                    mem_fwd, wb_fwd;

  // loads have no result in EX/MEM yet, so they only forward from MEM/WB
  assign mem_fwd   = is_wr(mem_op) && mem_op != OP_LD;
  assign wb_fwd    = is_wr(wb_op);
  assign fw_en     = {rd_rt(ex_op), rd_rs(ex_op)};
  assign fw_src    = {ex_rt, ex_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    pipeline_hazard_fwd_sel u_sel (
      .rd_en  (fw_en[g]),
      .mem_fwd(mem_fwd),
      .mem_rd (mem_rd),
      .wb_fwd (wb_fwd),
      .wb_rd  (wb_rd),
      .src    (fw_src[g]),
      .sel    (fw_sel[g])
    );
  end

  assign fwd_a = reset ? fw_sel[0] : 2'b00;
  assign fwd_b = reset ? fw_sel[1] : 2'b00;

  // hazard decode
  state_t     st;
  logic [1:0] cnt;
  logic       lu;
  logic       pc_w, ifid_w, ifid_f, idex_f;

  assign lu = (ex_op == OP_LD) &&
              ((rd_rs(id_op) && ex_rd == id_rs) || (rd_rt(id_op) && ex_rd == id_rt));

  always_comb begin
    pc_w   = 1'b1;
    ifid_w = 1'b1;
    ifid_f = 1'b0;
    idex_f = 1'b0;
    if (br_taken) begin
      ifid_f = 1'b1;
      idex_f = 1'b1;
    end else begin
      case (st)
        STALL: begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
        end
        FLUSH: begin
          ifid_f = 1'b1;
          if (lu) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_f = 1'b1;
          end
        end
        default: begin
          if (lu) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_f = 1'b1;
          end
        end
      endcase
    end
  end

  // reset forces the run-mode values without waiting for a clock
  assign pc_write   = pc_w   | ~reset;
  assign ifid_write = ifid_w | ~reset;
  assign ifid_flush = ifid_f &  reset;
  assign idex_flush = idex_f &  reset;
  assign state      = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= RUN;
      cnt       <= 2'd0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (!pc_w && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (ifid_f && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;

      if (br_taken) begin
        // a taken branch abandons any stall and (re)starts the flush window
        if (BR_PENALTY > 1) begin
          st  <= FLUSH;
          cnt <= BR_INIT;
        end else begin
          st  <= RUN;
          cnt <= 2'd0;
        end
      end else begin
        case (st)
          STALL: begin
            if (cnt <= 2'd1) begin
              st  <= RUN;
              cnt <= 2'd0;
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
          FLUSH: begin
            if (lu && LU_STALLS > 1) begin
              st  <= STALL;
              cnt <= LU_INIT;
            end else if (lu || cnt <= 2'd1) begin
              st  <= RUN;
              cnt <= 2'd0;
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
          default: begin
            // the first stall cycle is spent here in RUN
            if (lu && LU_STALLS > 1) begin
              st  <= STALL;
              cnt <= LU_INIT;
            end else begin
              st  <= RUN;
              cnt <= 2'd0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter LU_STALLS, default 1, load-use stall cycles per hazard (legal 1-3).
REQ-002 SHALL have parameter BR_PENALTY, default 1, IF/ID flush cycles per taken branch/jump (legal 1-3).
REQ-003 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 SHALL have port id_op  input  4  opcode of instruction in ID.
REQ-006 SHALL have port id_rs  input  6  rs field of instruction in ID.
REQ-007 SHALL have port id_rt  input  6  rt field of instruction in ID.
REQ-008 SHALL have port ex_op  input  4  opcode of instruction in EX.
REQ-009 SHALL have port ex_rd  input  6  rd field of instruction in EX.
REQ-010 SHALL have port ex_rs  input  6  rs field of instruction in EX.
REQ-011 SHALL have port ex_rt  input  6  rt field of instruction in EX.
REQ-012 SHALL have port mem_op  input  4  opcode of instruction in MEM.
REQ-013 SHALL have port mem_rd  input  6  rd field of instruction in MEM.
REQ-014 SHALL have port wb_op  input  4  opcode of instruction in WB.
REQ-015 SHALL have port wb_rd  input  6  rd field of instruction in WB.
REQ-016 SHALL have port br_taken  input  1  control-flow instruction in EX resolved taken this cycle.
REQ-017 SHALL have port pc_write  output  1  PC load enable.
REQ-018 SHALL have port ifid_write  output  1  IF/ID register load enable.
REQ-019 SHALL have port ifid_flush  output  1  replace IF/ID contents with NOP (0x00000000).
REQ-020 SHALL have port idex_flush  output  1  replace ID/EX contents with NOP (bubble).
REQ-021 SHALL have port fwd_a  output  2  EX rs operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
REQ-022 SHALL have port fwd_b  output  2  EX rt operand select, same encoding as fwd_a.
REQ-023 SHALL have port stall_cnt  output  16  saturating count of load-use stall cycles.
REQ-024 SHALL have port flush_cnt  output  16  saturating count of cycles with ifid_flush=1.
REQ-025 SHALL have port state  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.

Function
REQ-026 SHALL decode writer set W = {0100 ADD, 0101 INC, 0110 NEG, 0111 SUB, 1110 LD, 1111 SVPC}; no register is hardwired zero.
REQ-027 SHALL decode rs-readers = {0011, 0100-0111, 1000-1011, 1110}, rt-readers = {0011 ST, 0100, 0111}; opcode 0000 (NOP) reads and writes nothing.
REQ-028 SHALL compute fwd_a combinationally: 10 if ex_op reads rs, mem_op in W, mem_op != 1110, mem_rd == ex_rs; else 01 if ex_op reads rs, wb_op in W, wb_rd == ex_rs; else 00; fwd_b identical using ex_rt and rt-readers.
REQ-029 SHALL flag load-use hazard LU when ex_op == 1110 and (id reads rs and ex_rd == id_rs, or id reads rt and ex_rd == id_rt).
REQ-030 SHALL in RUN with LU and no br_taken drive pc_write=0, ifid_write=0, idex_flush=1 in the same cycle; next state STALL with count LU_STALLS-1 if LU_STALLS>1, else RUN.
REQ-031 SHALL in STALL hold pc_write=0, ifid_write=0, idex_flush=1, decrement the count each cycle, return to RUN after the count's last cycle; LU is ignored while in STALL.
REQ-032 SHALL on br_taken=1 in any state drive ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1 that cycle; next state FLUSH with count BR_PENALTY-1 if BR_PENALTY>1, else RUN.
REQ-033 SHALL in FLUSH drive ifid_flush=1, pc_write=1, idex_flush=0 and return to RUN after BR_PENALTY-1 cycles; LU is evaluated normally in FLUSH.
REQ-034 SHALL give br_taken priority over LU and over STALL: a pending stall is abandoned, and br_taken in FLUSH restarts the flush count.
REQ-035 SHALL increment stall_cnt every cycle with pc_write=0 and flush_cnt every cycle with ifid_flush=1, saturating at 0xFFFF without wrap.
REQ-036 SHALL in RUN with neither LU nor br_taken drive pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.

Reset
REQ-037 SHALL while reset=0, immediately and independent of clk, force state=00, internal counts=0, stall_cnt=0, flush_cnt=0, pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, fwd_a=fwd_b=00.
REQ-038 SHALL resume from RUN on the first rising clk after reset returns to 1; reset mid-STALL or mid-FLUSH aborts the sequence.

Verification
REQ-039 SHALL cover: ex_op=1110 ex_rd=5, id_op=0100 id_rs=5 -> same cycle pc_write=0, ifid_write=0, idex_flush=1; LU_STALLS=1: RUN next, stall_cnt=1; LU_STALLS=3: 3 stall cycles, stall_cnt=3.
REQ-040 SHALL cover: ex_op=0100 ex_rs=ex_rt=9, mem_op=0111 mem_rd=9, wb_op=0100 wb_rd=9 -> fwd_a=fwd_b=10; change mem_op to 1110 -> 01; ex_op=0110 -> fwd_b=00.
REQ-041 SHALL cover: br_taken=1 coincident with LU -> ifid_flush=idex_flush=1, pc_write=1, stall_cnt unchanged, flush_cnt+1.
REQ-042 SHALL cover: BR_PENALTY=3, br_taken pulse, second pulse 1 cycle later -> ifid_flush high 4 consecutive cycles, flush_cnt=4.
REQ-043 SHALL cover: id_op=0000 id_rs=ex_rd=5 with ex_op=1110 -> no stall; reset=0 asserted mid-STALL -> state=00, pc_write=1, counters 0 before next clk edge.
REQ-044 SHALL cover: stall_cnt preloaded to 0xFFFE by 3 further stall cycles -> reads 0xFFFF, no wrap.
